// File: rtl/uart_word_assembler.sv
// Packs UART receive bytes into NBYTES-wide words behind a valid/ready
// output register; partial words are dropped on idle timeout or clear.
module uart_word_assembler #(
  parameter int NBYTES         = 2,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  input  logic                        clear,
  output logic [8*NBYTES-1:0]         word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [$clog2(NBYTES+1)-1:0] byte_cnt,
  output logic                        overflow,
  output logic                        timeout_pulse
);

  localparam int W   = 8 * NBYTES;
  localparam int CW  = $clog2(NBYTES + 1);
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TEN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TLAST =
    TW'(TEN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CLAST = CW'(NBYTES - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  acc, acc_n, placed;
  logic [CW-1:0] cnt_n;
  logic [TW-1:0] idle, idle_n;
  logic          done, tout_n;

  // Current partial word with the incoming byte dropped into its slot.
  always_comb begin
    placed = acc;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_cnt == CW'(k)) begin
        if (LSB_FIRST) placed[8*k +: 8] = rx_data;
        else           placed[W-8-8*k +: 8] = rx_data;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = byte_cnt;
    acc_n   = acc;
    idle_n  = idle;
    done    = 1'b0;
    tout_n  = 1'b0;
    if (rx_ready) begin
      idle_n = '0;
      if (byte_cnt == CLAST) begin
        done    = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
        acc_n   = '0;
      end else begin
        state_n = COLLECT;
        cnt_n   = byte_cnt + CW'(1);
        acc_n   = placed;
      end
    end else if (TEN && state == COLLECT) begin
      if (idle == TLAST) begin
        state_n = IDLE;
        cnt_n   = '0;
        acc_n   = '0;
        idle_n  = '0;
        tout_n  = 1'b1;
      end else begin
        idle_n = idle + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      byte_cnt      <= '0;
      idle          <= '0;
      word_out      <= '0;
      word_valid    <= 1'b0;
      overflow      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      acc           <= '0;
      byte_cnt      <= '0;
      idle          <= '0;
      word_valid    <= 1'b0;
      overflow      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      byte_cnt      <= cnt_n;
      idle          <= idle_n;
      timeout_pulse <= tout_n;
      // A held word blocks the new one unless consumed on this same edge.
      if (done) begin
        if (!word_valid || word_ready) begin
          word_out   <= placed;
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: three configurations driven from shared
// inputs, directed scenarios plus randomized traffic against a byte-list model.
module tb_uart_word_assembler;

  logic       clk = 1'b0;
  logic       reset, rx_ready, clear, word_ready;
  logic [7:0] rx_data;

  logic [15:0] a_wo;
  logic [31:0] b_wo;
  logic [7:0]  c_wo;
  logic [1:0]  a_bc;
  logic [2:0]  b_bc;
  logic [0:0]  c_bc;
  logic        a_v, b_v, c_v, a_o, b_o, c_o, a_p, b_p, c_p;

  always #5 clk = ~clk;

  uart_word_assembler #(.NBYTES(2), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .clear(clear), .word_out(a_wo), .word_valid(a_v), .word_ready(word_ready),
    .byte_cnt(a_bc), .overflow(a_o), .timeout_pulse(a_p));

  uart_word_assembler #(.NBYTES(4), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .clear(clear), .word_out(b_wo), .word_valid(b_v), .word_ready(word_ready),
    .byte_cnt(b_bc), .overflow(b_o), .timeout_pulse(b_p));

  uart_word_assembler #(.NBYTES(1), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(4)) dut_c (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .clear(clear), .word_out(c_wo), .word_valid(c_v), .word_ready(word_ready),
    .byte_cnt(c_bc), .overflow(c_o), .timeout_pulse(c_p));

  logic [63:0] d_wo [3];
  logic [7:0]  d_bc [3];
  logic        d_v [3], d_o [3], d_p [3];

  assign d_wo[0] = {48'h0, a_wo};
  assign d_wo[1] = {32'h0, b_wo};
  assign d_wo[2] = {56'h0, c_wo};
  assign d_bc[0] = {6'h0, a_bc};
  assign d_bc[1] = {5'h0, b_bc};
  assign d_bc[2] = {7'h0, c_bc};
  assign d_v[0] = a_v;  assign d_v[1] = b_v;  assign d_v[2] = c_v;
  assign d_o[0] = a_o;  assign d_o[1] = b_o;  assign d_o[2] = c_o;
  assign d_p[0] = a_p;  assign d_p[1] = b_p;  assign d_p[2] = c_p;

  localparam int MN [3] = '{2, 4, 1};
  localparam int ML [3] = '{1, 0, 1};
  localparam int MT [3] = '{16, 0, 4};

  // Model: list of bytes received so far, idle-cycle count, output slot.
  logic [7:0]  pb [3][8];
  int          pn [3];
  int          idl [3];
  logic [63:0] m_wo [3];
  logic        m_v [3], m_o [3], m_p [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic        fin, took;
      logic [63:0] w;
      fin  = 1'b0;
      took = m_v[i] && word_ready;
      if (reset) begin
        pn[i] = 0; idl[i] = 0; m_wo[i] = '0;
        m_v[i] = 0; m_o[i] = 0; m_p[i] = 0;
      end else if (clear) begin
        pn[i] = 0; idl[i] = 0;
        m_v[i] = 0; m_o[i] = 0; m_p[i] = 0;
      end else begin
        m_p[i] = 0;
        if (rx_ready) begin
          pb[i][pn[i]] = rx_data;
          pn[i]++;
          idl[i] = 0;
          if (pn[i] == MN[i]) begin
            w = '0;
            for (int k = 0; k < MN[i]; k++) begin
              if (ML[i] == 1) w = w | (64'(pb[i][k]) << (8 * k));
              else            w = (w << 8) | 64'(pb[i][k]);
            end
            pn[i] = 0;
            fin = 1'b1;
            if (!m_v[i] || word_ready) begin
              m_wo[i] = w;
              m_v[i] = 1;
            end else begin
              m_o[i] = 1;
            end
          end
        end else if (pn[i] > 0 && MT[i] > 0) begin
          idl[i]++;
          if (idl[i] == MT[i]) begin
            pn[i] = 0; idl[i] = 0; m_p[i] = 1;
          end
        end
        if (!fin && took) m_v[i] = 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic step(input logic r, input logic [7:0] d, input logic wr,
                      input logic cl, input logic rs);
    @(negedge clk);
    rx_ready = r; rx_data = d; word_ready = wr; clear = cl; reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checks += 5;
      if (d_wo[i] !== 64'h0) begin errors++; $display("FAIL reset_word[%0d] got %h want 0", i, d_wo[i]); end
      if (d_v[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b want 0", i, d_v[i]); end
      if (d_bc[i] !== 8'h0) begin errors++; $display("FAIL reset_cnt[%0d] got %0d want 0", i, d_bc[i]); end
      if (d_o[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d] got %b want 0", i, d_o[i]); end
      if (d_p[i] !== 1'b0) begin errors++; $display("FAIL reset_pulse[%0d] got %b want 0", i, d_p[i]); end
    end
  endtask

  task automatic test_lsb_word();
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h34, 1, 0, 0);
    checks += 3;
    if (a_bc !== 2'd1) begin errors++; $display("FAIL lsb_cnt1 got %0d want 1", a_bc); end
    if (c_v !== 1'b1) begin errors++; $display("FAIL n1_valid got %b want 1", c_v); end
    if (c_wo !== 8'h34 || c_bc !== 1'b0) begin errors++; $display("FAIL n1_word got %h/%0d want 34/0", c_wo, c_bc); end
    step(1, 8'h12, 1, 0, 0);
    checks += 2;
    if (a_v !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", a_v); end
    if (a_wo !== 16'h1234) begin errors++; $display("FAIL lsb_word got %h want 1234", a_wo); end
    step(0, 8'h00, 1, 0, 0);
    checks += 3;
    if (a_v !== 1'b0) begin errors++; $display("FAIL lsb_consume got %b want 0", a_v); end
    if (a_o !== 1'b0) begin errors++; $display("FAIL lsb_ovf got %b want 0", a_o); end
    if (a_wo !== 16'h1234) begin errors++; $display("FAIL lsb_hold got %h want 1234", a_wo); end
  endtask

  task automatic test_msb_word();
    logic [7:0] bs [4];
    logic [2:0] ec [4];
    bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ec = '{3'd1, 3'd2, 3'd3, 3'd0};
    step(0, 8'h00, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, bs[k], 1, 0, 0);
      checks++;
      if (b_bc !== ec[k]) begin errors++; $display("FAIL msb_cnt%0d got %0d want %0d", k, b_bc, ec[k]); end
    end
    checks += 2;
    if (b_wo !== 32'hDEADBEEF) begin errors++; $display("FAIL msb_word got %h want deadbeef", b_wo); end
    if (b_v !== 1'b1) begin errors++; $display("FAIL msb_valid got %b want 1", b_v); end
  endtask

  task automatic test_overflow();
    step(0, 8'h00, 0, 0, 1);
    for (int k = 1; k <= 4; k++) step(1, 8'(k), 0, 0, 0);
    checks += 3;
    if (a_wo !== 16'h0201) begin errors++; $display("FAIL ovf_word got %h want 0201", a_wo); end
    if (a_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", a_o); end
    if (a_v !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", a_v); end
    step(1, 8'h99, 0, 1, 0);
    checks += 4;
    if (a_v !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", a_v); end
    if (a_o !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", a_o); end
    if (a_wo !== 16'h0201) begin errors++; $display("FAIL clr_word got %h want 0201", a_wo); end
    if (a_bc !== 2'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", a_bc); end
  endtask

  task automatic test_timeout();
    int pc;
    pc = 0;
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'hAA, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 8'h00, 1, 0, 0);
      if (a_p === 1'b1) pc++;
    end
    checks += 3;
    if (pc != 1) begin errors++; $display("FAIL to_pulses got %0d want 1", pc); end
    if (a_bc !== 2'd0) begin errors++; $display("FAIL to_cnt got %0d want 0", a_bc); end
    if (b_bc !== 3'd1) begin errors++; $display("FAIL to_disabled_cnt got %0d want 1", b_bc); end
    step(1, 8'h55, 1, 0, 0);
    step(1, 8'h66, 1, 0, 0);
    checks += 2;
    if (a_wo !== 16'h6655) begin errors++; $display("FAIL to_word got %h want 6655", a_wo); end
    if (a_v !== 1'b1) begin errors++; $display("FAIL to_valid got %b want 1", a_v); end
  endtask

  task automatic test_back_to_back();
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 1, 0, 0);
    checks += 3;
    if (a_v !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", a_v); end
    if (a_wo !== 16'h4433) begin errors++; $display("FAIL b2b_word got %h want 4433", a_wo); end
    if (a_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", a_o); end
  endtask

  task automatic test_reset_mid();
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    checks++;
    if (a_bc !== 2'd1 || a_v !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d/%b want 1/1", a_bc, a_v); end
    step(1, 8'h04, 0, 0, 1);
    checks++;
    if ({a_wo, a_v, a_bc, a_o, a_p} !== 21'h0) begin
      errors++; $display("FAIL mid_reset got %h/%b/%0d/%b/%b want all 0", a_wo, a_v, a_bc, a_o, a_p);
    end
    step(1, 8'h0F, 1, 0, 0);
    step(1, 8'hF0, 1, 0, 0);
    checks++;
    if (a_wo !== 16'hF00F || a_v !== 1'b1) begin errors++; $display("FAIL mid_frame got %h/%b want f00f/1", a_wo, a_v); end
  endtask

  task automatic test_random();
    int dense;
    step(0, 8'h00, 0, 0, 1);
    dense = 1;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) dense = ($urandom_range(1) == 1) ? 1 : 0;
      step(dense ? ($urandom_range(3) != 0) : ($urandom_range(19) == 0),
           8'($urandom_range(255)), 1'($urandom_range(1)),
           $urandom_range(99) == 0, $urandom_range(299) == 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_wo[i] !== m_wo[i] || d_v[i] !== m_v[i] || d_bc[i] !== 8'(pn[i]) ||
            d_o[i] !== m_o[i] || d_p[i] !== m_p[i]) begin
          errors++;
          $display("FAIL rand[%0d] cyc %0d got w=%h v=%b c=%0d o=%b p=%b want w=%h v=%b c=%0d o=%b p=%b",
                   i, n, d_wo[i], d_v[i], d_bc[i], d_o[i], d_p[i],
                   m_wo[i], m_v[i], pn[i], m_o[i], m_p[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
    clear = 1'b0; word_ready = 1'b0;
    test_reset();
    test_lsb_word();
    test_msb_word();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Collects a stream of UART receive bytes (rx_data qualified by the rx_ready pulse from uart_basic) into words of parametrised byte count.
- Byte order is selectable. Each completed word is presented through a valid/ready output register with an overflow flag.
- Partially received words are discarded on inter-byte timeout or on clear.
- Sits between uart_basic and downstream consumers (LED/display logic, command decoders). It replaces ad-hoc shift registers in the top level.

Parameters:
- NBYTES, 2, bytes per word; legal 1..8; word width W = 8*NBYTES.
- LSB_FIRST, 1, 1: first received byte lands in word[7:0]; 0: first received byte lands in word[W-1:W-8].
- TIMEOUT_CYCLES, 1000000, clk cycles of idle allowed between bytes of one word before the partial word is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only when rx_ready=1
- rx_ready  in  1  single-cycle strobe, one per received byte
- clear  in  1  synchronous flush of partial word and output register
- word_out  out  W  assembled word, stable while word_valid=1
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word when word_valid&&word_ready at posedge
- byte_cnt  out  $clog2(NBYTES+1)  bytes held in current partial word
- overflow  out  1  sticky: a completed word was dropped
- timeout_pulse  out  1  one-cycle pulse: partial word dropped by timeout

Behaviour:
- Reset (reset=1 at posedge): state=IDLE, shift/assembly register=0, byte_cnt=0, word_out=0, word_valid=0, overflow=0, timeout_pulse=0, idle counter=0. Reset has priority over all other inputs.
- clear (reset=0): same effect as reset on state, assembly register, byte_cnt, idle counter and word_valid. word_out keeps its value; overflow is also cleared. clear outranks rx_ready in the same cycle, so that byte is discarded.
- State machine has two states: IDLE (byte_cnt=0) and COLLECT (0<byte_cnt<NBYTES).
- IDLE, rx_ready=1: the byte is placed at its slot; byte_cnt=1 and state becomes COLLECT. If NBYTES=1, the word completes on that same edge and the block stays in IDLE.
- COLLECT, rx_ready=1: the byte is placed at slot byte_cnt and byte_cnt increments. The idle counter reloads to 0.
- Byte placement:
  - LSB_FIRST=1: byte k goes to bits [8k+7:8k].
  - LSB_FIRST=0: byte k goes to bits [W-1-8k:W-8-8k].
- Word completion: on the edge where the NBYTES-th byte is accepted, byte_cnt returns to 0, the state returns to IDLE and the assembly register clears. The full word is offered to the output register on that same edge. Latency from the last rx_ready to word_valid=1 is 1 clk.
- Output register load rules on the completion edge:
  - word_valid=0: load, word_valid=1.
  - word_valid=1 and word_ready=1 in the same cycle: old word is consumed, new word loaded, word_valid stays 1, no overflow.
  - word_valid=1 and word_ready=0: new word dropped, word_out unchanged, overflow=1 (sticky until reset/clear).
- Consumption without completion: word_valid&&word_ready drops word_valid to 0 at that edge; word_out holds its value.
- Timeout, TIMEOUT_CYCLES>0:
  - The idle counter increments each clk in COLLECT without rx_ready.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_ready that cycle, the next edge discards the partial word: byte_cnt=0, state=IDLE, assembly register=0. timeout_pulse=1 for exactly that one following cycle.
  - The counter does not run in IDLE.
  - rx_ready in the would-be timeout cycle wins; the byte is accepted and there is no timeout.
- The output register and word_valid are unaffected by timeout.
- rx_ready is treated as a strobe; held high for k cycles it counts as k bytes.

Test Plan:
- NBYTES=2, LSB_FIRST=1: bytes 0x34 then 0x12, word_ready=1 -> word_valid=1 one clk after second strobe, word_out=0x1234, consumed next edge, overflow=0.
- NBYTES=4, LSB_FIRST=0: bytes 0xDE,0xAD,0xBE,0xEF -> word_out=0xDEADBEEF; byte_cnt steps 1,2,3,0.
- NBYTES=2, word_ready=0: send 4 bytes 0x01,0x02,0x03,0x04 -> word_out stays 0x0201, overflow=1. Then clear=1 -> word_valid=0, overflow=0, word_out=0x0201.
- NBYTES=2, TIMEOUT_CYCLES=16: one byte 0xAA then 20 idle cycles -> timeout_pulse high exactly 1 cycle, byte_cnt=0. Then bytes 0x55,0x66 -> word_out=0x6655 (no 0xAA residue).
- Back-to-back: word_valid=1 with word_ready=1 on the completion edge of the next word -> word_valid stays 1, word_out updates, overflow=0.
- reset asserted mid-word (byte_cnt=1, word_valid=1) -> all outputs 0 next edge. A following 2-byte frame assembles correctly.
